timer_tick_scheduler: RTL and testbench

Multiplexes one periodic hardware tick across NUM_CH virtual software timers, each with its own reload value, one-shot or periodic mode, expiry flag and interrupt enable. The per-channel counts are held in a register array. A single shared decrement unit sweeps that array one channel per clock after each tick. The block is an Avalon-MM slave on the Nios II subsystem bus, alongside the interval timer whose timeout pulse drives tick_in.

---
 rtl/timer_sched_pkg.sv | 24 ++
 rtl/timer_tick_scheduler_if.sv | 22 ++
 rtl/timer_sched_regfile.sv | 119 +++++++++++
 rtl/timer_tick_scheduler.sv | 144 ++++++++++++++
 tb/tb_timer_tick_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_sched_pkg.sv
// Shared constants and types for the timer tick scheduler.
//   Register word addresses, DIAG bit positions and the scan FSM state type.
package timer_sched_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_STATUS      = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN      = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_START       = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_STOP        = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_MODE        = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_DIAG        = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_RELOAD_BASE = 4'd8;

    localparam int unsigned DIAG_OVERRUN_BIT = 0;
    localparam int unsigned DIAG_BUSY_BIT    = 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sched_state_e;

endpackage

// File: rtl/timer_tick_scheduler_if.sv
// Avalon-MM slave bus bundle for the timer tick scheduler.
//   address/chipselect/write_n/writedata driven by the master,
//   readdata returned by the slave with one cycle of latency.
interface timer_tick_scheduler_if;
    import timer_sched_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/timer_sched_regfile.sv
// Bus decode, readdata mux and per-channel mask registers.
//   bus           : Avalon-MM slave (readdata registered every cycle)
//   i_count       : live channel counts, returned on RELOAD_i reads
//   i_exp_set     : expiry events from the scan (win over STATUS clears)
//   i_run_clr     : one-shot completions from the scan
//   i_ovr_set     : dropped-tick event (wins over DIAG clear)
//   i_busy        : scan FSM active, reported in DIAG
//   o_running/o_periodic : mask registers
//   o_start_c/o_stop_c/o_reload_we_c : decoded write strobes for this cycle
//   o_irq         : registered OR of expired & irq_en
module timer_sched_regfile
    import timer_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    timer_tick_scheduler_if.slave        bus,
    input  logic [NUM_CH-1:0][CNT_W-1:0] i_count,
    input  logic [NUM_CH-1:0]            i_exp_set,
    input  logic [NUM_CH-1:0]            i_run_clr,
    input  logic                         i_ovr_set,
    input  logic                         i_busy,
    output logic [NUM_CH-1:0]            o_running,
    output logic [NUM_CH-1:0]            o_periodic,
    output logic [NUM_CH-1:0]            o_start_c,
    output logic [NUM_CH-1:0]            o_stop_c,
    output logic [NUM_CH-1:0]            o_reload_we_c,
    output logic                         o_irq
);

    logic [NUM_CH-1:0] r_expired, r_irq_en, r_running, r_periodic;
    logic              r_overrun, r_irq;
    logic [NUM_CH-1:0] w_exp_nxt, w_irq_en_nxt, w_run_nxt, w_per_nxt;
    logic              w_ovr_nxt;
    logic              w_wr;
    logic [NUM_CH-1:0] w_mask;
    logic [DATA_W-1:0] w_rdata;

    assign w_wr   = bus.chipselect & ~bus.write_n;
    assign w_mask = bus.writedata[NUM_CH-1:0];

    // Write decode and next values; scan events are applied so that
    // expiry/overrun beat clears and START/STOP beat the scan.
    always_comb begin
        o_start_c     = '0;
        o_stop_c      = '0;
        o_reload_we_c = '0;
        w_exp_nxt     = r_expired;
        w_irq_en_nxt  = r_irq_en;
        w_per_nxt     = r_periodic;
        w_ovr_nxt     = r_overrun;

        if (w_wr) begin
            if (bus.address == ADDR_STATUS) w_exp_nxt    = r_expired & ~w_mask;
            if (bus.address == ADDR_IRQ_EN) w_irq_en_nxt = w_mask;
            if (bus.address == ADDR_START)  o_start_c    = w_mask;
            if (bus.address == ADDR_STOP)   o_stop_c     = w_mask;
            if (bus.address == ADDR_MODE)   w_per_nxt    = w_mask;
            if (bus.address == ADDR_DIAG && bus.writedata[DIAG_OVERRUN_BIT])
                w_ovr_nxt = 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (bus.address == ADDR_RELOAD_BASE + ADDR_W'(i))
                    o_reload_we_c[i] = 1'b1;
            end
        end

        w_exp_nxt = w_exp_nxt | i_exp_set;
        w_ovr_nxt = w_ovr_nxt | i_ovr_set;
        w_run_nxt = ((r_running & ~i_run_clr) | o_start_c) & ~o_stop_c;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_STATUS: w_rdata = DATA_W'(r_expired);
            ADDR_IRQ_EN: w_rdata = DATA_W'(r_irq_en);
            ADDR_START:  w_rdata = DATA_W'(r_running);
            ADDR_MODE:   w_rdata = DATA_W'(r_periodic);
            ADDR_DIAG: begin
                w_rdata[DIAG_OVERRUN_BIT] = r_overrun;
                w_rdata[DIAG_BUSY_BIT]    = i_busy;
            end
            default: begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    if (bus.address == ADDR_RELOAD_BASE + ADDR_W'(i))
                        w_rdata = DATA_W'(i_count[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_expired    <= '0;
            r_irq_en     <= '0;
            r_running    <= '0;
            r_periodic   <= '0;
            r_overrun    <= 1'b0;
            r_irq        <= 1'b0;
            bus.readdata <= '0;
        end else begin
            r_expired    <= w_exp_nxt;
            r_irq_en     <= w_irq_en_nxt;
            r_running    <= w_run_nxt;
            r_periodic   <= w_per_nxt;
            r_overrun    <= w_ovr_nxt;
            r_irq        <= |(w_exp_nxt & w_irq_en_nxt);
            bus.readdata <= w_rdata;
        end
    end

    assign o_running  = r_running;
    assign o_periodic = r_periodic;
    assign o_irq      = r_irq;

endmodule

// File: rtl/timer_tick_scheduler.sv
// Multiplexes one periodic tick across NUM_CH virtual software timers.
//   clk, reset_n : clock and asynchronous active-low reset
//   tick_in      : single-cycle tick pulse from the interval timer
//   bus          : Avalon-MM slave register interface
//   irq          : OR of expired & irq_en, registered
// After each tick a shared decrement path sweeps one channel per clock.
module timer_tick_scheduler
    import timer_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick_in,
    timer_tick_scheduler_if.slave bus,
    output logic                  irq
);

    localparam int unsigned   IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    sched_state_e             r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_scan_idx, w_idx_nxt;
    logic                     r_tick_pending, w_pend_nxt;
    logic                     w_ovr_set;

    logic [NUM_CH-1:0][CNT_W-1:0] r_count, r_reload;
    logic [NUM_CH-1:0]        w_running, w_periodic;
    logic [NUM_CH-1:0]        w_start, w_stop, w_reload_we;
    logic [NUM_CH-1:0]        w_exp_set, w_run_clr, w_upd, w_idx_oh;
    logic [CNT_W-1:0]         w_cnt_sel, w_rel_sel, w_cnt_nxt;
    logic                     w_run_sel, w_per_sel;

    timer_sched_regfile #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_regfile (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .i_count       (r_count),
        .i_exp_set     (w_exp_set),
        .i_run_clr     (w_run_clr),
        .i_ovr_set     (w_ovr_set),
        .i_busy        (r_state == SCAN),
        .o_running     (w_running),
        .o_periodic    (w_periodic),
        .o_start_c     (w_start),
        .o_stop_c      (w_stop),
        .o_reload_we_c (w_reload_we),
        .o_irq         (irq)
    );

    // Scan FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_scan_idx     <= '0;
            r_tick_pending <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_scan_idx     <= w_idx_nxt;
            r_tick_pending <= w_pend_nxt;
        end
    end

    // Scan FSM next state; a tick in the last scan cycle restarts directly.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_scan_idx;
        w_pend_nxt  = r_tick_pending;
        w_ovr_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tick_in) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (tick_in && r_tick_pending) w_ovr_set = 1'b1;
                if (r_scan_idx == LAST_IDX) begin
                    w_idx_nxt  = '0;
                    w_pend_nxt = 1'b0;
                    if (!(r_tick_pending || tick_in)) w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_scan_idx + IDX_W'(1);
                    if (tick_in) w_pend_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shared decrement/compare path for the channel under scan.
    always_comb begin
        w_idx_oh  = '0;
        w_cnt_sel = '0;
        w_rel_sel = '0;
        w_run_sel = 1'b0;
        w_per_sel = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (r_scan_idx == IDX_W'(i)) begin
                w_idx_oh[i] = 1'b1;
                w_cnt_sel   = r_count[i];
                w_rel_sel   = r_reload[i];
                w_run_sel   = w_running[i];
                w_per_sel   = w_periodic[i];
            end
        end

        w_exp_set = '0;
        w_run_clr = '0;
        w_upd     = '0;
        w_cnt_nxt = w_cnt_sel;
        // A START/STOP on this channel this cycle discards the scan result.
        if (r_state == SCAN && w_run_sel && ((w_start | w_stop) & w_idx_oh) == '0) begin
            w_upd = w_idx_oh;
            if (w_cnt_sel == '0) begin
                w_exp_set = w_idx_oh;
                if (w_per_sel) w_cnt_nxt = w_rel_sel;
                else           w_run_clr = w_idx_oh;
            end else begin
                w_cnt_nxt = w_cnt_sel - CNT_W'(1);
            end
        end
    end

    // Count and reload arrays.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_reload <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (w_reload_we[i]) r_reload[i] <= bus.writedata[CNT_W-1:0];
                if (w_start[i])     r_count[i]  <= r_reload[i];
                else if (w_upd[i])  r_count[i]  <= w_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Self-checking bench for timer_tick_scheduler: directed timing scenarios
// plus a randomized register/tick sequence checked against a tick-level model.
module tb_timer_tick_scheduler;
    import timer_sched_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick_in = 1'b0;
    logic irq;

    timer_tick_scheduler_if bus();

    timer_tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_in (tick_in),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: channel state advanced one whole tick at a time.
    logic [15:0]       m_count  [NUM_CH];
    logic [15:0]       m_reload [NUM_CH];
    logic [NUM_CH-1:0] m_expired, m_irq_en, m_running, m_periodic;
    logic              m_overrun;

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_count[i]  = '0;
            m_reload[i] = '0;
        end
        m_expired = '0; m_irq_en = '0; m_running = '0; m_periodic = '0;
        m_overrun = 1'b0;
    endtask

    task automatic model_tick();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (m_running[i]) begin
                if (m_count[i] == 0) begin
                    m_expired[i] = 1'b1;
                    if (m_periodic[i]) m_count[i] = m_reload[i];
                    else               m_running[i] = 1'b0;
                end else begin
                    m_count[i] = m_count[i] - 16'd1;
                end
            end
        end
    endtask

    task automatic model_write(input int a, input logic [15:0] d);
        case (a)
            0: m_expired  = m_expired & ~d[NUM_CH-1:0];
            1: m_irq_en   = d[NUM_CH-1:0];
            2: for (int i = 0; i < int'(NUM_CH); i++)
                   if (d[i]) begin m_running[i] = 1'b1; m_count[i] = m_reload[i]; end
            3: m_running  = m_running & ~d[NUM_CH-1:0];
            4: m_periodic = d[NUM_CH-1:0];
            5: if (d[0]) m_overrun = 1'b0;
            default: if (a >= 8 && a < 8 + int'(NUM_CH)) m_reload[a-8] = d;
        endcase
    endtask

    function automatic logic [15:0] model_read(input int a);
        case (a)
            0: return 16'(m_expired);
            1: return 16'(m_irq_en);
            2: return 16'(m_running);
            4: return 16'(m_periodic);
            5: return {15'd0, m_overrun};
            default: return (a >= 8 && a < 8 + int'(NUM_CH)) ? m_count[a-8] : 16'd0;
        endcase
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    endtask

    task automatic bus_write(input int a, input logic [15:0] d);
        bus.address = 4'(a); bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        cyc();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input int a, output logic [15:0] d);
        bus.address = 4'(a); bus.chipselect = 1'b1; bus.write_n = 1'b1;
        cyc();
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic tick();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
    endtask

    task automatic settle();
        repeat (2 * NUM_CH + 4) cyc();
    endtask

    task automatic do_reset();
        idle_bus();
        tick_in = 1'b0;
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        idle_bus();
        reset_n = 1'b0;
        cyc();
        n_tests++;
        if (bus.readdata !== 16'd0) begin n_fail++; $display("FAIL reset_readdata: got %0h expected 0", bus.readdata); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset_n = 1'b1;
        cyc();
        for (int a = 0; a < 16; a++) begin
            bus_read(a, d);
            n_tests++;
            if (d !== 16'd0) begin n_fail++; $display("FAIL reset_reg[%0d]: got %0h expected 0", a, d); end
        end
        // Writes without chipselect or to unmapped words must not land.
        bus.address = ADDR_IRQ_EN; bus.writedata = 16'hF; bus.write_n = 1'b0; bus.chipselect = 1'b0;
        cyc();
        bus.write_n = 1'b1;
        bus_write(6, 16'hFFFF);
        bus_write(12, 16'h1234);
        bus_read(1, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL nocs_write: got %0h expected 0", d); end
        bus_read(12, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL unmapped_read: got %0h expected 0", d); end
    endtask

    task automatic test_oneshot();
        logic [15:0] d;
        do_reset();
        bus_write(8, 16'd2);
        bus_write(ADDR_MODE, 16'd0);
        bus_write(ADDR_START, 16'h1);
        bus_read(8, d);
        n_tests++;
        if (d !== 16'd2) begin n_fail++; $display("FAIL oneshot_count_start: got %0d expected 2", d); end
        tick(); repeat (20) cyc();
        bus_read(8, d);
        n_tests++;
        if (d !== 16'd1) begin n_fail++; $display("FAIL oneshot_count_t1: got %0d expected 1", d); end
        tick(); repeat (20) cyc();
        bus_read(8, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL oneshot_count_t2: got %0d expected 0", d); end
        bus_read(ADDR_STATUS, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL oneshot_early_expire: got %0h expected 0", d); end
        tick(); repeat (20) cyc();
        bus_read(ADDR_STATUS, d);
        n_tests++;
        if (d !== 16'h1) begin n_fail++; $display("FAIL oneshot_expired: got %0h expected 1", d); end
        bus_read(ADDR_START, d);
        n_tests++;
        if (d !== 16'h0) begin n_fail++; $display("FAIL oneshot_running: got %0h expected 0", d); end
        bus_read(8, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL oneshot_count_t3: got %0d expected 0", d); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_masked: got %b expected 0", irq); end
    endtask

    task automatic test_periodic_irq();
        logic [15:0] d;
        do_reset();
        bus_write(ADDR_IRQ_EN, 16'h1);
        bus_write(ADDR_MODE, 16'h1);
        bus_write(8, 16'd0);
        bus_write(ADDR_START, 16'h1);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_irq_pre: got %b expected 0", irq); end
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_irq_t1: got %b expected 0", irq); end
        cyc();
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL periodic_irq_t2: got %b expected 1", irq); end
        settle();
        bus_write(ADDR_STATUS, 16'h1);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_irq_clear: got %b expected 0", irq); end
        tick(); settle();
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL periodic_irq_again: got %b expected 1", irq); end
        bus_read(8, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL periodic_count: got %0d expected 0", d); end
    endtask

    task automatic test_busy_timing();
        logic exp_busy;
        logic [15:0] exp_cnt;
        do_reset();
        bus_write(11, 16'd5);
        bus_write(ADDR_START, 16'h8);
        bus.address = ADDR_DIAG;
        cyc();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_busy = (k >= 2 && k <= 5);
            n_tests++;
            if (bus.readdata[1] !== exp_busy) begin
                n_fail++; $display("FAIL busy_T+%0d: got %b expected %b", k, bus.readdata[1], exp_busy);
            end
            cyc();
        end
        settle();
        bus.address = 4'd11;
        cyc();
        n_tests++;
        if (bus.readdata !== 16'd4) begin n_fail++; $display("FAIL ch3_count_after_t1: got %0d expected 4", bus.readdata); end
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_cnt = (k >= 6) ? 16'd3 : 16'd4;
            n_tests++;
            if (bus.readdata !== exp_cnt) begin
                n_fail++; $display("FAIL ch3_count_T+%0d: got %0d expected %0d", k, bus.readdata, exp_cnt);
            end
            cyc();
        end
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < int'(NUM_CH); i++) bus_write(8 + i, 16'd9);
        bus_write(ADDR_START, 16'hF);
        tick_in = 1'b1;
        repeat (3) cyc();
        tick_in = 1'b0;
        repeat (3 * NUM_CH + 4) cyc();
        bus_read(ADDR_DIAG, d);
        n_tests++;
        if (d !== 16'h1) begin n_fail++; $display("FAIL overrun_diag: got %0h expected 1", d); end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            bus_read(8 + i, d);
            n_tests++;
            if (d !== 16'd7) begin n_fail++; $display("FAIL overrun_count[%0d]: got %0d expected 7", i, d); end
        end
        bus_write(ADDR_DIAG, 16'h1);
        bus_read(ADDR_DIAG, d);
        n_tests++;
        if (d !== 16'h0) begin n_fail++; $display("FAIL overrun_clear: got %0h expected 0", d); end
    endtask

    task automatic test_start_collision();
        logic [15:0] d;
        do_reset();
        bus_write(9, 16'd3);
        bus_write(ADDR_START, 16'h2);
        bus_write(9, 16'd9);
        bus_read(9, d);
        n_tests++;
        if (d !== 16'd3) begin n_fail++; $display("FAIL reload_keeps_count: got %0d expected 3", d); end
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        bus_write(ADDR_START, 16'h2);
        settle();
        bus_read(9, d);
        n_tests++;
        if (d !== 16'd9) begin n_fail++; $display("FAIL start_collision_count: got %0d expected 9", d); end
        bus_read(ADDR_START, d);
        n_tests++;
        if (d !== 16'h2) begin n_fail++; $display("FAIL start_collision_running: got %0h expected 2", d); end
        tick(); settle();
        bus_read(9, d);
        n_tests++;
        if (d !== 16'd8) begin n_fail++; $display("FAIL start_collision_next: got %0d expected 8", d); end
    endtask

    task automatic test_reset_midscan();
        logic [15:0] d;
        do_reset();
        bus_write(ADDR_IRQ_EN, 16'hF);
        bus_write(ADDR_MODE, 16'hF);
        bus_write(ADDR_START, 16'hF);
        tick(); settle();
        bus_read(ADDR_STATUS, d);
        n_tests++;
        if (d !== 16'hF) begin n_fail++; $display("FAIL midscan_pre_status: got %0h expected F", d); end
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL midscan_pre_irq: got %b expected 1", irq); end
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.readdata !== 16'd0) begin n_fail++; $display("FAIL midscan_readdata: got %0h expected 0", bus.readdata); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midscan_irq: got %b expected 0", irq); end
        cyc();
        reset_n = 1'b1;
        cyc();
        for (int a = 0; a < 12; a++) begin
            bus_read(a, d);
            n_tests++;
            if (d !== 16'd0) begin n_fail++; $display("FAIL midscan_reg[%0d]: got %0h expected 0", a, d); end
        end
        bus_write(8, 16'd1);
        bus_write(ADDR_START, 16'h1);
        bus.address = 4'd8;
        cyc();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc(); cyc();
        n_tests++;
        if (bus.readdata !== 16'd0) begin n_fail++; $display("FAIL midscan_fresh_ch0: got %0d expected 0", bus.readdata); end
    endtask

    task automatic test_random();
        logic [15:0] d, e;
        int op, a;
        do_reset();
        model_reset();
        for (int r = 0; r < 80; r++) begin
            op = int'($urandom_range(0, 8));
            case (op)
                0: begin
                    a = 8 + int'($urandom_range(0, NUM_CH - 1));
                    d = 16'($urandom_range(0, 4));
                    bus_write(a, d); model_write(a, d);
                end
                1, 2, 3, 4, 5: begin
                    a = (op == 1) ? 4 : (op == 2) ? 1 : (op == 3) ? 2 : (op == 4) ? 3 : 0;
                    d = 16'($urandom_range(0, 15));
                    bus_write(a, d); model_write(a, d);
                end
                default: begin
                    tick(); settle(); model_tick();
                end
            endcase
            n_tests++;
            if (irq !== |(m_expired & m_irq_en)) begin
                n_fail++; $display("FAIL rand_irq step %0d: got %b expected %b", r, irq, |(m_expired & m_irq_en));
            end
            a = int'($urandom_range(0, 15));
            if (a == 3) a = 2;
            bus_read(a, d);
            e = model_read(a);
            n_tests++;
            if (d !== e) begin n_fail++; $display("FAIL rand_read step %0d addr %0d: got %0h expected %0h", r, a, d, e); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        idle_bus();
        test_reset();
        test_oneshot();
        test_periodic_irq();
        test_busy_timing();
        test_overrun();
        test_start_collision();
        test_reset_midscan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
